seq_divider: RTL

- Iterative radix-2 restoring unsigned divider; the inverse of the team's pipelined multiplier.
- Divides a 2W-bit dividend (a multiplier product) by a W-bit divisor, giving a W-bit quotient and W-bit remainder in W cycles.
- Uses a valid/ready handshake on both sides.
- Sits after the multiplier in round-trip benches and in datapaths that need product normalisation.

---
 rtl/div_pkg.sv | 14 +
 rtl/seq_divider_if.sv | 25 ++
 rtl/div_step.sv | 18 +
 rtl/seq_divider.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and sizing helpers for the sequential restoring divider.
package div_pkg;

    localparam int W_DEF = 16;
    localparam int CNT_W = $clog2(W_DEF);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_e;
    typedef enum logic [1:0] {NORMAL, DZ, OVF} div_kind_e;

    function automatic int cnt_bits(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/seq_divider_if.sv
// rtl/seq_divider_if.sv - operand/result handshake bundle for seq_divider.
interface seq_divider_if #(
    parameter int W = 16
) ();
    logic           in_valid;
    logic           in_ready;
    logic [2*W-1:0] dividend;
    logic [W-1:0]   divisor;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   quotient;
    logic [W-1:0]   remainder;
    logic           div_by_zero;
    logic           overflow;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division step: shift in a bit, trial-subtract.
module div_step #(
    parameter int W = 16
) (
    input  logic [W-1:0] rem,
    input  logic         bit_in,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_next,
    output logic         q_bit
);
    logic [W:0] t;
    logic [W:0] diff;

    assign t        = {rem, bit_in};
    assign diff     = t - {1'b0, divisor};
    assign q_bit    = (t >= {1'b0, divisor});
    assign rem_next = q_bit ? diff[W-1:0] : t[W-1:0];
endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - iterative radix-2 restoring divider, 2W/W -> W quotient + W remainder.
// DIV_BYPASS_EN: divide-by-zero and overflow results skip the iteration and finish in one cycle.
module seq_divider
    import div_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    seq_divider_if.slave bus
);
    localparam int CW = cnt_bits(W);

    div_state_e    state_q, state_d;
    div_kind_e     kind_q, kind_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  rem_q, rem_d;
    logic [W-1:0]  lo_q, lo_d;
    logic [W-1:0]  dvs_q, dvs_d;
    logic [W-1:0]  quo_q, quo_d;
    logic [W-1:0]  erem_q, erem_d;
    logic [W-1:0]  quotient_q, quotient_d;
    logic [W-1:0]  remainder_q, remainder_d;
    logic          dz_q, dz_d;
    logic          ovf_q, ovf_d;

    logic [W-1:0]  step_rem;
    logic          step_q_bit;

    div_step #(.W(W)) u_step (
        .rem      (rem_q),
        .bit_in   (lo_q[W-1]),
        .divisor  (dvs_q),
        .rem_next (step_rem),
        .q_bit    (step_q_bit)
    );

    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        lo_d        = lo_q;
        dvs_d       = dvs_q;
        quo_d       = quo_q;
        erem_d      = erem_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dz_d        = dz_q;
        ovf_d       = ovf_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    dvs_d   = bus.divisor;
                    rem_d   = bus.dividend[2*W-1:W];
                    lo_d    = bus.dividend[W-1:0];
                    quo_d   = '0;
                    cnt_d   = CW'(W - 1);
                    state_d = BUSY;
                    if (bus.divisor == '0)
                        kind_d = DZ;
                    else if (bus.dividend[2*W-1:W] >= bus.divisor)
                        kind_d = OVF;
                    else
                        kind_d = NORMAL;
                    // The low half is shifted away during BUSY, so keep the divide-by-zero remainder aside.
                    erem_d = (kind_d == DZ) ? bus.dividend[W-1:0] : '0;
`ifdef DIV_BYPASS_EN
                    if (kind_d != NORMAL) begin
                        state_d     = DONE;
                        quotient_d  = '1;
                        remainder_d = erem_d;
                        dz_d        = (kind_d == DZ);
                        ovf_d       = (kind_d == OVF);
                    end
`endif
                end
            end
            BUSY: begin
                rem_d = step_rem;
                lo_d  = {lo_q[W-2:0], 1'b0};
                quo_d = {quo_q[W-2:0], step_q_bit};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = DONE;
                    if (kind_q == NORMAL) begin
                        quotient_d  = quo_d;
                        remainder_d = step_rem;
                    end else begin
                        quotient_d  = '1;
                        remainder_d = erem_q;
                    end
                    dz_d  = (kind_q == DZ);
                    ovf_d = (kind_q == OVF);
                end
            end
            DONE: begin
                if (bus.out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            kind_q      <= NORMAL;
            cnt_q       <= '0;
            rem_q       <= '0;
            lo_q        <= '0;
            dvs_q       <= '0;
            quo_q       <= '0;
            erem_q      <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dz_q        <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            lo_q        <= lo_d;
            dvs_q       <= dvs_d;
            quo_q       <= quo_d;
            erem_q      <= erem_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dz_q        <= dz_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.in_ready    = (state_q == IDLE);
    assign bus.out_valid   = (state_q == DONE);
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dz_q;
    assign bus.overflow    = ovf_q;
endmodule
